// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: mult/div FSM states
// and EX operand forwarding selects.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam int MD_CNT_W = 4;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline (master) drives
// the stage fields; the controller (slave) returns stall/flush/forward controls.
interface hazard_controller_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
);
    logic [RA_W-1:0]  ID_rs;
    logic [RA_W-1:0]  ID_rt;
    logic             ID_UsesRs;
    logic             ID_UsesRt;
    logic             ID_IsMD;
    logic [RA_W-1:0]  EX_rs;
    logic [RA_W-1:0]  EX_rt;
    logic             EX_MemRead;
    logic             EX_MDStart;
    logic             EX_BrTaken;
    logic             MEM_RegWrite;
    logic [RA_W-1:0]  MEM_rd;
    logic             WB_RegWrite;
    logic [RA_W-1:0]  WB_rd;
    logic             PC_Stall;
    logic             ID_Bubble;
    logic             IFID_Flush;
    logic [1:0]       ForwardA;
    logic [1:0]       ForwardB;
    logic             MD_Busy;
    logic             MD_Done;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_IsMD,
        output EX_rs, EX_rt, EX_MemRead, EX_MDStart, EX_BrTaken,
        output MEM_RegWrite, MEM_rd, WB_RegWrite, WB_rd,
        input  PC_Stall, ID_Bubble, IFID_Flush, ForwardA, ForwardB,
        input  MD_Busy, MD_Done, StallCount
    );

    modport slave (
        input  ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_IsMD,
        input  EX_rs, EX_rt, EX_MemRead, EX_MDStart, EX_BrTaken,
        input  MEM_RegWrite, MEM_rd, WB_RegWrite, WB_rd,
        output PC_Stall, ID_Bubble, IFID_Flush, ForwardA, ForwardB,
        output MD_Busy, MD_Done, StallCount
    );
endinterface

// File: rtl/hazard_controller_forward_sel.sv
// Per-operand forwarding select: the younger MEM result beats the WB result;
// register 0 is never forwarded.
module forward_sel
    import hazard_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            mem_wr_i,
    input  logic [RA_W-1:0] mem_rd_i,
    input  logic            wb_wr_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic [RA_W-1:0] ex_src_i,
    output logic [1:0]      fwd_o
);

    // Priority compare MEM over WB
    always_comb begin
        fwd_o = FWD_RF;
        if (mem_wr_i && (mem_rd_i != '0) && (mem_rd_i == ex_src_i)) begin
            fwd_o = FWD_MEM;
        end else if (wb_wr_i && (wb_rd_i != '0) && (wb_rd_i == ex_src_i)) begin
            fwd_o = FWD_WB;
        end else begin
            fwd_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch flush, EX forwarding and
// mult/div sequencing. Optional stall counter under `HAZ_PERF_CNT_EN.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int RA_W       = 5,
    parameter int CNT_W      = 32
) (
    input  logic               Clk,
    input  logic               Reset_n,
    hazard_controller_if.slave hz
);

    md_state_e             state_q;
    logic [MD_CNT_W-1:0]   md_cnt_q;
    logic                  load_use_s;
    logic                  md_stall_s;
    logic [1:0]            fwd_a_s;
    logic [1:0]            fwd_b_s;

    assign load_use_s = hz.EX_MemRead && (hz.EX_rt != '0) &&
                        ((hz.ID_UsesRs && (hz.ID_rs == hz.EX_rt)) ||
                         (hz.ID_UsesRt && (hz.ID_rt == hz.EX_rt)));
    assign md_stall_s = (state_q != IDLE) && hz.ID_IsMD;

    // Combinational controls are masked during reset; a taken branch overrides the stall
    assign hz.PC_Stall   = Reset_n && !hz.EX_BrTaken && (load_use_s || md_stall_s);
    assign hz.ID_Bubble  = Reset_n && (hz.EX_BrTaken || load_use_s || md_stall_s);
    assign hz.IFID_Flush = Reset_n && hz.EX_BrTaken;
    assign hz.ForwardA   = Reset_n ? fwd_a_s : FWD_RF;
    assign hz.ForwardB   = Reset_n ? fwd_b_s : FWD_RF;
    assign hz.MD_Busy    = (state_q == BUSY) || (state_q == DONE);
    assign hz.MD_Done    = (state_q == DONE);

    forward_sel #(.RA_W(RA_W)) u_fwd_a (
        .mem_wr_i (hz.MEM_RegWrite),
        .mem_rd_i (hz.MEM_rd),
        .wb_wr_i  (hz.WB_RegWrite),
        .wb_rd_i  (hz.WB_rd),
        .ex_src_i (hz.EX_rs),
        .fwd_o    (fwd_a_s)
    );

    forward_sel #(.RA_W(RA_W)) u_fwd_b (
        .mem_wr_i (hz.MEM_RegWrite),
        .mem_rd_i (hz.MEM_rd),
        .wb_wr_i  (hz.WB_RegWrite),
        .wb_rd_i  (hz.WB_rd),
        .ex_src_i (hz.EX_rt),
        .fwd_o    (fwd_b_s)
    );

    // Mult/div occupancy FSM: BUSY lasts MD_LATENCY-1 cycles, DONE one more
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            md_cnt_q <= {MD_CNT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz.EX_MDStart && !hz.EX_BrTaken) begin
                        state_q  <= BUSY;
                        md_cnt_q <= MD_CNT_W'(MD_LATENCY - 2);
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                BUSY: begin
                    if (md_cnt_q == {MD_CNT_W{1'b0}}) begin
                        state_q  <= DONE;
                    end else begin
                        md_cnt_q <= md_cnt_q - MD_CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    md_cnt_q <= {MD_CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating count of PC stall cycles
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else if (hz.PC_Stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign hz.StallCount = stall_cnt_q;
`else
    assign hz.StallCount = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: expected control vectors are queued as
// each step is driven, then popped and checked against the DUT outputs.
module tb_hazard_controller;

    localparam int RA_W  = 5;
    localparam int CNT_W = 32;

    logic Clk;
    logic Reset_n;

    hazard_controller_if #(.RA_W(RA_W), .CNT_W(CNT_W)) hz ();

    hazard_controller #(.MD_LATENCY(4), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .hz      (hz)
    );

    int vectors;
    int miscompares;
    logic [8:0] sb_q[$];
    string      tag_q[$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic clear_inputs();
        hz.ID_rs = 5'd0;  hz.ID_rt = 5'd0;  hz.ID_UsesRs = 1'b0; hz.ID_UsesRt = 1'b0;
        hz.ID_IsMD = 1'b0; hz.EX_rs = 5'd0; hz.EX_rt = 5'd0; hz.EX_MemRead = 1'b0;
        hz.EX_MDStart = 1'b0; hz.EX_BrTaken = 1'b0; hz.MEM_RegWrite = 1'b0;
        hz.MEM_rd = 5'd0; hz.WB_RegWrite = 1'b0; hz.WB_rd = 5'd0;
    endtask

    // exp = {PC_Stall, ID_Bubble, IFID_Flush, ForwardA, ForwardB, MD_Busy, MD_Done}
    task automatic check(input string tag, input logic [8:0] exp);
        logic [8:0] e;
        logic [8:0] got;
        string      t;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        e   = sb_q.pop_front();
        t   = tag_q.pop_front();
        got = {hz.PC_Stall, hz.ID_Bubble, hz.IFID_Flush, hz.ForwardA, hz.ForwardB,
               hz.MD_Busy, hz.MD_Done};
        vectors++;
        assert (got === e) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", t, got, e);
        end
    endtask

    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] exp);
        vectors++;
        assert (hz.StallCount === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, hz.StallCount, exp);
        end
    endtask

    initial begin
        logic [CNT_W-1:0] exp_cnt;
        vectors = 0;
        miscompares = 0;
        Reset_n = 1'b0;
        clear_inputs();

        // Reset with every hazard source active: all outputs must be 0
        @(negedge Clk);
        hz.EX_MemRead = 1'b1; hz.EX_rt = 5'd8; hz.ID_rs = 5'd8; hz.ID_UsesRs = 1'b1;
        hz.EX_BrTaken = 1'b1; hz.EX_rs = 5'd9; hz.MEM_RegWrite = 1'b1; hz.MEM_rd = 5'd9;
        check("reset_outputs", 9'b0_0_0_00_00_0_0);
        check_cnt("reset_count", 32'd0);
        @(negedge Clk);
        clear_inputs();
        Reset_n = 1'b1;
        check("reset_release", 9'b0_0_0_00_00_0_0);

        // 1: load-use, then forward from WB
        @(negedge Clk);
        clear_inputs();
        hz.EX_MemRead = 1'b1; hz.EX_rt = 5'd8; hz.ID_rs = 5'd8; hz.ID_UsesRs = 1'b1;
        check("load_use_rs", 9'b1_1_0_00_00_0_0);
        @(negedge Clk);
        clear_inputs();
        hz.EX_rs = 5'd8; hz.WB_RegWrite = 1'b1; hz.WB_rd = 5'd8;
        check("load_use_fwd_wb", 9'b0_0_0_01_00_0_0);
        @(negedge Clk);
        clear_inputs();
        hz.EX_MemRead = 1'b1; hz.EX_rt = 5'd8; hz.ID_rt = 5'd8; hz.ID_UsesRt = 1'b0;
        check("load_use_unused_rt", 9'b0_0_0_00_00_0_0);

        // 2: forwarding priority
        @(negedge Clk);
        clear_inputs();
        hz.EX_rs = 5'd9; hz.EX_rt = 5'd9;
        hz.MEM_RegWrite = 1'b1; hz.MEM_rd = 5'd9; hz.WB_RegWrite = 1'b1; hz.WB_rd = 5'd9;
        check("fwd_mem_priority", 9'b0_0_0_10_10_0_0);
        @(negedge Clk);
        hz.MEM_RegWrite = 1'b0;
        check("fwd_wb_fallback", 9'b0_0_0_01_01_0_0);
        @(negedge Clk);
        hz.MEM_RegWrite = 1'b1; hz.MEM_rd = 5'd0; hz.WB_rd = 5'd0;
        hz.EX_rs = 5'd0; hz.EX_rt = 5'd0;
        check("fwd_r0_never", 9'b0_0_0_00_00_0_0);
        @(negedge Clk);
        clear_inputs();
        hz.EX_rs = 5'd9; hz.EX_rt = 5'd5;
        hz.MEM_RegWrite = 1'b1; hz.MEM_rd = 5'd9; hz.WB_RegWrite = 1'b1; hz.WB_rd = 5'd5;
        check("fwd_split_ab", 9'b0_0_0_10_01_0_0);

        // 3: branch beats load-use stall
        @(negedge Clk);
        clear_inputs();
        hz.EX_MemRead = 1'b1; hz.EX_rt = 5'd8; hz.ID_rs = 5'd8; hz.ID_UsesRs = 1'b1;
        hz.EX_BrTaken = 1'b1;
        check("branch_over_stall", 9'b0_1_1_00_00_0_0);

        // 4: mult/div with mflo waiting in ID
        @(negedge Clk);
        clear_inputs();
        hz.EX_MDStart = 1'b1; hz.ID_IsMD = 1'b1;
        check("md_start", 9'b0_0_0_00_00_0_0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            hz.EX_MDStart = 1'b0;
            check($sformatf("md_busy_%0d", i), 9'b1_1_0_00_00_1_0);
        end
        @(negedge Clk);
        check("md_done", 9'b1_1_0_00_00_1_1);
        @(negedge Clk);
        check("md_release", 9'b0_0_0_00_00_0_0);
`ifdef HAZ_PERF_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        check_cnt("stall_count", exp_cnt);

        // Start suppressed by a taken branch; branch during BUSY does not abort
        @(negedge Clk);
        clear_inputs();
        hz.EX_MDStart = 1'b1; hz.EX_BrTaken = 1'b1;
        check("md_start_branch", 9'b0_1_1_00_00_0_0);
        @(negedge Clk);
        clear_inputs();
        check("md_not_started", 9'b0_0_0_00_00_0_0);
        @(negedge Clk);
        hz.EX_MDStart = 1'b1;
        check("md_start2", 9'b0_0_0_00_00_0_0);
        @(negedge Clk);
        clear_inputs();
        hz.EX_BrTaken = 1'b1; hz.ID_IsMD = 1'b1;
        check("md_busy_branch", 9'b0_1_1_00_00_1_0);
        @(negedge Clk);
        clear_inputs();
        check("md_busy_no_dep", 9'b0_0_0_00_00_1_0);

        // 5: asynchronous reset in BUSY
        @(negedge Clk);
        hz.ID_IsMD = 1'b1;
        Reset_n = 1'b0;
        check("md_async_reset", 9'b0_0_0_00_00_0_0);
        check_cnt("count_after_reset", 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("md_no_done_%0d", i), 9'b0_0_0_00_00_0_0);
            @(negedge Clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
